// File: rtl/cpu_pkg.sv
// Shared constants, opcode map, FSM encoding and instruction field helpers
// for the multi-cycle 16-bit load/store CPU.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NREG   = 8;
  localparam int REG_W  = $clog2(NREG);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_ORR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_B   = 4'h8;
  localparam logic [3:0] OP_BZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  function automatic logic [3:0] f_op(input logic [DATA_W-1:0] ins);
    return ins[15:12];
  endfunction

  function automatic logic [REG_W-1:0] f_rd(input logic [DATA_W-1:0] ins);
    return ins[11:9];
  endfunction

  function automatic logic [REG_W-1:0] f_rs(input logic [DATA_W-1:0] ins);
    return ins[8:6];
  endfunction

  function automatic logic [REG_W-1:0] f_rt(input logic [DATA_W-1:0] ins);
    return ins[5:3];
  endfunction

  function automatic logic [5:0] f_imm6(input logic [DATA_W-1:0] ins);
    return ins[5:0];
  endfunction

  function automatic logic [8:0] f_imm9(input logic [DATA_W-1:0] ins);
    return ins[8:0];
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr8(input logic [DATA_W-1:0] ins);
    return ins[7:0];
  endfunction

endpackage

// File: rtl/cpu_ram.sv
// Unified instruction/data RAM: combinational read, synchronous single-port write.
// The array is preloaded hierarchically by benches, so it keeps its name and shape.
module cpu_ram
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  reg [DATA_W-1:0] memory [0:2**ADDR_W-1];

  // NOTE: the array has no reset so a preloaded program survives rst, and
  // non-blocking assignment keeps the write ordered after same-edge reads.
  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle load/store CPU: FETCH -> EXEC (-> MEM for loads) -> FETCH, HALT on HLT.
// rf, pc, ir and state are kept under these names for hierarchical probing.
module cpu_core
  import cpu_pkg::*;
(
  input logic clk,
  input logic rst
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rf [0:NREG-1];
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] addr;

  logic [3:0]        op;
  logic [REG_W-1:0]  rd, rs, rt;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] alu_y;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              ir_load, pc_load, addr_load, rf_we, rf_from_mem;
  logic [DATA_W-1:0] rf_wdata;

  assign op = f_op(ir);
  assign rd = f_rd(ir);
  assign rs = f_rs(ir);
  assign rt = f_rt(ir);
  // Effective address wraps modulo the RAM size.
  assign ea = rf[rs][ADDR_W-1:0] + ADDR_W'(f_imm6(ir));

  cpu_ram ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (rf[rd]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if      (op == OP_LDR) state_nxt = MEM;
        else if (op == OP_HLT) state_nxt = HALT;
        else                   state_nxt = FETCH;
      end
      MEM:   state_nxt = FETCH;
      HALT:  state_nxt = HALT;
    endcase
  end

  always_comb begin
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    addr_load   = 1'b0;
    rf_we       = 1'b0;
    rf_from_mem = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = pc;
    unique case (state)
      FETCH: ir_load = 1'b1;
      EXEC: begin
        case (op)
          OP_LDR: addr_load = 1'b1;
          OP_STR: begin
            ram_we   = 1'b1;
            ram_addr = ea;
          end
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV: rf_we = 1'b1;
          OP_B:   pc_load = 1'b1;
          OP_BZ:  pc_load = (rf[rd] == '0);
          default: ;
        endcase
      end
      MEM: begin
        ram_addr    = addr;
        rf_we       = 1'b1;
        rf_from_mem = 1'b1;
      end
      HALT: ;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = rf[rs] + rf[rt];
      OP_SUB:  alu_y = rf[rs] - rf[rt];
      OP_AND:  alu_y = rf[rs] & rf[rt];
      OP_ORR:  alu_y = rf[rs] | rf[rt];
      OP_MOV:  alu_y = DATA_W'(f_imm9(ir));
      default: alu_y = '0;
    endcase
  end

  assign rf_wdata = rf_from_mem ? ram_rdata : alu_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      ir   <= '0;
      addr <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (ir_load) begin
        ir <= ram_rdata;
        pc <= pc + ADDR_W'(1);
      end
      if (pc_load)   pc       <= f_addr8(ir);
      if (addr_load) addr     <= ea;
      if (rf_we)     rf[rd]   <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: an instruction-level ISA model predicts the final
// machine state and cycle count; a monitor compares once the core halts.
module tb_cpu_core;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_core dut (.clk(clk), .rst(rst));

  typedef struct packed {
    logic [7:0]          id;
    logic                at_reset;
    logic [7:0]          pc;
    logic [7:0][15:0]    rf;
    logic [255:0][15:0]  mem;
    logic [31:0]         cycles;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  bit done     = 1'b0;

  logic [15:0] p_mem [256];
  logic [15:0] m_mem [256];
  logic [15:0] m_rf  [8];
  int          m_pc, m_cycles;
  bit          m_halted;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (test %0d): got %h expected %h", name, id, act, exp);
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int lo6);
    return {4'(op), 3'(rd), 3'(rs), 6'(lo6)};
  endfunction

  function automatic logic [15:0] enc_mov(input int rd, input int imm9);
    return {4'h7, 3'(rd), 9'(imm9)};
  endfunction

  function automatic logic [15:0] enc_br(input int op, input int rd, input int a8);
    return {4'(op), 3'(rd), 1'b0, 8'(a8)};
  endfunction

  // Instruction-level reference: one loop iteration per instruction.
  task automatic model_run();
    logic [15:0] ins;
    int op, rd, rs, rt, a, b, ea;
    m_pc = 0; m_cycles = 0; m_halted = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    for (int step = 0; step < 400 && !m_halted; step++) begin
      ins  = m_mem[m_pc];
      m_pc = (m_pc + 1) % 256;
      op = int'(ins[15:12]); rd = int'(ins[11:9]); rs = int'(ins[8:6]); rt = int'(ins[5:3]);
      a  = int'(m_rf[rs]);   b  = int'(m_rf[rt]);
      ea = (a + int'(ins[5:0])) % 256;
      m_cycles += (op == 1) ? 3 : 2;
      case (op)
        1:  m_rf[rd] = m_mem[ea];
        2:  m_mem[ea] = m_rf[rd];
        3:  m_rf[rd] = 16'((a + b) % 65536);
        4:  m_rf[rd] = 16'((a - b + 65536) % 65536);
        5:  m_rf[rd] = m_rf[rs] & m_rf[rt];
        6:  m_rf[rd] = m_rf[rs] | m_rf[rt];
        7:  m_rf[rd] = 16'(int'(ins[8:0]));
        8:  m_pc = int'(ins[7:0]);
        9:  if (m_rf[rd] == 16'h0) m_pc = int'(ins[7:0]);
        15: m_halted = 1;
        default: ;
      endcase
    end
  endtask

  task automatic push_expected(input int id, input bit at_reset);
    exp_t x;
    x.id = 8'(id); x.at_reset = at_reset; x.pc = 8'(m_pc); x.cycles = 32'(m_cycles);
    for (int i = 0; i < 8; i++)   x.rf[i]  = m_rf[i];
    for (int i = 0; i < 256; i++) x.mem[i] = m_mem[i];
    done = 1'b0;
    q.push_back(x);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) p_mem[i] = 16'h0;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 256; i++) dut.ram.memory[i] = p_mem[i];
  endtask

  task automatic wait_done(input int id);
    for (int k = 0; k < 10000 && !done; k++) @(negedge clk);
    check("monitor_done", id, 32'(done), 32'd1);
  endtask

  task automatic run_prog(input int id);
    load_dut();
    m_mem = p_mem;
    model_run();
    push_expected(id, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start_cyc = cyc;
    wait_done(id);
    rst = 1'b1;
  endtask

  task automatic compare_state(input exp_t x);
    int idx;
    check("pc", x.id, 32'(dut.pc), 32'(x.pc));
    for (int i = 0; i < 8; i++) check($sformatf("rf[%0d]", i), x.id, 32'(dut.rf[i]), 32'(x.rf[i]));
    idx = 0;
    for (int i = 255; i >= 0; i--) if (dut.ram.memory[i] !== x.mem[i]) idx = i;
    check($sformatf("mem[%0h]", idx), x.id, 32'(dut.ram.memory[idx]), 32'(x.mem[idx]));
  endtask

  // Monitor: pops one expectation and compares when the core presents its result.
  initial begin
    bit halted;
    forever begin
      wait (q.size() > 0);
      e = q.pop_front();
      if (e.at_reset) begin
        @(negedge clk);
        check("state_in_reset", e.id, 32'(dut.state), 32'(FETCH));
        check("ir_in_reset", e.id, 32'(dut.ir), 32'h0);
        compare_state(e);
      end else begin
        halted = 1'b0;
        for (int k = 0; k < 3000 && !halted; k++) begin
          @(negedge clk);
          if (dut.state == HALT) halted = 1'b1;
        end
        check("halted", e.id, 32'(dut.state), 32'(HALT));
        if (halted) begin
          check("cycles", e.id, 32'(cyc - start_cyc), e.cycles);
          compare_state(e);
        end
      end
      done = 1'b1;
    end
  end

  task automatic gen_random();
    int n, k;
    clear_prog();
    for (int i = 128; i < 256; i++) p_mem[i] = 16'($urandom);
    n = $urandom_range(12, 4);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(7, 0);
      case (k)
        0: p_mem[i] = enc_mov($urandom_range(7, 0), $urandom_range(511, 0));
        1, 2, 3, 4: p_mem[i] = enc(k + 2, $urandom_range(7, 0), $urandom_range(7, 0),
                                   $urandom_range(7, 0) * 8);
        5: p_mem[i] = enc(1, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(63, 0));
        6: p_mem[i] = enc(2, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(63, 0));
        default: p_mem[i] = {4'($urandom_range(14, 10)), 12'($urandom)};
      endcase
    end
    p_mem[n] = 16'hF000;
  endtask

  initial begin
    int good;
    repeat (3) @(negedge clk);

    // 1: basic load
    clear_prog();
    p_mem[0] = enc(1, 1, 0, 6'h20); p_mem[1] = 16'hF000; p_mem[8'h20] = 16'h1234;
    run_prog(1);

    // 2: load address wraps 0xFF+2 -> 0x01
    clear_prog();
    p_mem[0] = enc_mov(2, 9'h0FF); p_mem[1] = enc(1, 3, 2, 2); p_mem[2] = 16'hF000;
    run_prog(2);

    // 3: store then load the same address
    clear_prog();
    p_mem[0] = enc_mov(1, 9'h055); p_mem[1] = enc(2, 1, 0, 6'h30);
    p_mem[2] = enc(1, 4, 0, 6'h30); p_mem[3] = 16'hF000;
    run_prog(3);

    // 4: SUB to zero, taken BZ skips MOV r5
    clear_prog();
    p_mem[0] = enc_mov(1, 3); p_mem[1] = enc_mov(2, 3); p_mem[2] = enc(4, 3, 1, 2 * 8);
    p_mem[3] = enc_br(9, 3, 8'h10); p_mem[4] = enc_mov(5, 1); p_mem[5] = 16'hF000;
    p_mem[8'h10] = 16'hF000;
    run_prog(4);

    // 5: reset asserted during MEM of an LDR, then re-run
    clear_prog();
    p_mem[0] = enc_mov(1, 7); p_mem[1] = enc(1, 2, 1, 6'h20);
    p_mem[2] = enc(2, 2, 0, 6'h40); p_mem[3] = 16'hF000; p_mem[8'h27] = 16'hABCD;
    load_dut();
    @(negedge clk);
    rst = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 20 && dut.state != MEM; k++) @(negedge clk);
    check("reach_mem", 5, 32'(dut.state), 32'(MEM));
    rst = 1'b1;
    m_mem = p_mem; m_pc = 0; m_cycles = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    push_expected(5, 1'b1);
    wait_done(5);
    m_mem = p_mem;
    model_run();
    push_expected(5, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start_cyc = cyc;
    wait_done(5);
    rst = 1'b1;

    // 6: LDR, ADD, HLT takes 3+2+2 edges
    clear_prog();
    p_mem[0] = enc(1, 1, 0, 6'h20); p_mem[1] = enc(3, 2, 1, 1 * 8); p_mem[2] = 16'hF000;
    p_mem[8'h20] = 16'h0101;
    run_prog(6);

    // Random straight-line programs
    good = 0;
    for (int t = 0; t < 200 && good < 20; t++) begin
      gen_random();
      m_mem = p_mem;
      model_run();
      if (m_halted) begin
        run_prog(10 + good);
        good++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
